// File: rtl/gf2m_409_pkg.sv
// Shared definitions for the GF(2^409) field blocks (f = x^409 + x^87 + 1).
package gf2m_409_pkg;

  localparam int M      = 409;
  localparam int K      = 87;
  localparam int WD_MAX = 4*M + 2;
  localparam int STEP_W = $clog2(4*M + 3);
  localparam int DEG_W  = $clog2(M + 1);

  localparam logic [M:0]   ONE_W     = {{M{1'b0}}, 1'b1};
  localparam logic [M:0]   FPOLY     = (ONE_W << M) | (ONE_W << K) | ONE_W;
  // f >> 1 with the constant term dropped: folds x^-1 reduction into a plain XOR
  localparam logic [M-1:0] HALF_POLY = FPOLY[M:1];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Index of the leading one; 0 for a zero operand.
  function automatic logic [DEG_W-1:0] deg_of(input logic [M:0] p);
    logic [DEG_W-1:0] d;
    d = '0;
    for (int i = 0; i <= M; i++) begin
      if (p[i]) d = DEG_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/gf2m_halve_409.sv
// Combinational g * x^-1 mod f for GF(2^409).
module gf2m_halve_409
  import gf2m_409_pkg::*;
(
  input  logic [M-1:0] g_i,
  output logic [M-1:0] half_o
);

  // Odd g: add f first so the shift is exact; the x^0 term of f cancels g[0].
  always_comb begin
    half_o = {1'b0, g_i[M-1:1]} ^ (g_i[0] ? HALF_POLY : '0);
  end

endmodule

// File: rtl/gf2m_inverter_409.sv
// Sequential GF(2^409) inverter, LSB-first binary extended Euclid, one step per clock.
//
//  state | meaning
//  IDLE  | waiting for start; result and err held
//  RUN   | one Euclid step per cycle until u==1, v==1, a==0 or watchdog
//  FIN   | done pulse; inv/err valid from here on
module gf2m_inverter_409
  import gf2m_409_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] a,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [M-1:0] inv
);

  state_e            state_q, state_d;
  logic [M:0]        u_q, u_d, v_q, v_d;
  logic [M-1:0]      g1_q, g1_d, g2_q, g2_d;
  logic [M-1:0]      inv_q, inv_d;
  logic [M-1:0]      g1_half, g2_half;
  logic              err_q, err_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              u_zero, u_one, v_one, wd_hit, finish;

  gf2m_halve_409 u_halve_g1 (.g_i(g1_q), .half_o(g1_half));
  gf2m_halve_409 u_halve_g2 (.g_i(g2_q), .half_o(g2_half));

  // Termination conditions evaluated on the current u/v/step
  always_comb begin
    u_zero = (u_q == '0);
    u_one  = (u_q == ONE_W);
    v_one  = (v_q == ONE_W);
    wd_hit = (step_q >= STEP_W'(WD_MAX));
    finish = u_zero | u_one | v_one | wd_hit;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a==0 also passes through RUN so every op takes at least two cycles
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (finish) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FIN);
    err  = err_q;
    inv  = inv_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      u_q    <= '0;
      v_q    <= '0;
      g1_q   <= '0;
      g2_q   <= '0;
      inv_q  <= '0;
      err_q  <= 1'b0;
      step_q <= '0;
    end else begin
      u_q    <= u_d;
      v_q    <= v_d;
      g1_q   <= g1_d;
      g2_q   <= g2_d;
      inv_q  <= inv_d;
      err_q  <= err_d;
      step_q <= step_d;
    end
  end

  // Euclid step; invariants g1*a == u and g2*a == v (mod f)
  always_comb begin
    u_d    = u_q;
    v_d    = v_q;
    g1_d   = g1_q;
    g2_d   = g2_q;
    inv_d  = inv_q;
    err_d  = err_q;
    step_d = step_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          u_d    = {1'b0, a};
          v_d    = FPOLY;
          g1_d   = {{(M-1){1'b0}}, 1'b1};
          g2_d   = '0;
          err_d  = 1'b0;
          step_d = '0;
        end
      end
      RUN: begin
        step_d = step_q + 1'b1;
        if (u_zero) begin
          err_d = 1'b1;
          inv_d = '0;
        end else if (u_one) begin
          inv_d = g1_q;
        end else if (v_one) begin
          inv_d = g2_q;
        end else if (wd_hit) begin
          err_d = 1'b1;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          g1_d = g1_half;
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          g2_d = g2_half;
        end else if (deg_of(u_q) > deg_of(v_q)) begin
          u_d  = u_q ^ v_q;
          g1_d = g1_q ^ g2_q;
        end else begin
          v_d  = v_q ^ u_q;
          g2_d = g2_q ^ g1_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gf2m_inverter_409.sv
// Bench for gf2m_inverter_409: results are checked by field multiplication against the
// accepted operand, plus timing/hold rules tracked cycle by cycle.
module tb_gf2m_inverter_409;

  localparam int M       = 409;
  localparam int K       = 87;
  localparam int LAT_MAX = 4*M + 3;
  localparam int N_RAND  = 60;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [M-1:0] a;
  logic         busy;
  logic         done;
  logic         err;
  logic [M-1:0] inv;

  int checks   = 0;
  int failures = 0;

  gf2m_inverter_409 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .busy (busy),
    .done (done),
    .err  (err),
    .inv  (inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkv(input string nm, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Plain shift-and-add field multiply mod x^409 + x^87 + 1
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M-1:0] r, s, red;
    r = '0;
    s = x;
    red = '0;
    red[K] = 1'b1;
    red[0] = 1'b1;
    for (int i = 0; i < M; i++) begin
      if (y[i]) r = r ^ s;
      s = {s[M-2:0], 1'b0} ^ (s[M-1] ? red : '0);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand_a();
    logic [415:0] w;
    logic [M-1:0] r;
    for (int i = 0; i < 13; i++) w[i*32 +: 32] = $urandom;
    r = w[M-1:0];
    if (r == '0) r[0] = 1'b1;
    return r;
  endfunction

  logic [M-1:0] one_v, x_v, inv_x_v, ones_v;

  // ---------------- reference model + per-cycle compare ----------------
  bit           mvalid = 0;
  bit           mbusy  = 0;
  int           lat    = 0;
  int           accepts = 0;
  int           results = 0;
  logic [M-1:0] macc_a;
  logic [M-1:0] exp_inv;
  logic         exp_err;

  always @(negedge clk) begin
    if (mvalid) begin
      if (mbusy) begin
        lat++;
        check1("busy_while_active", busy, 1'b1);
        if (done) begin
          results++;
          checki("latency_within_bound", (lat <= LAT_MAX) ? 1 : 0, 1);
          if (macc_a == '0) begin
            check1("zero_err", err, 1'b1);
            checkv("zero_inv", inv, '0);
            checki("zero_latency", lat, 2);
          end else begin
            check1("nonzero_err", err, 1'b0);
            checkv("a_times_inv", gf_mul(macc_a, inv), one_v);
            if (macc_a == one_v) begin
              checkv("inv_of_one", inv, one_v);
              checki("one_latency", lat, 2);
            end
            if (macc_a == x_v) checkv("inv_of_x", inv, inv_x_v);
          end
          exp_err = (macc_a == '0);
          exp_inv = inv;
        end else begin
          check1("err_clear_in_run", err, 1'b0);
          if (lat > LAT_MAX) begin
            checki("done_before_bound", lat, LAT_MAX);
            mvalid = 0;
          end
        end
      end else begin
        check1("idle_busy", busy, 1'b0);
        check1("idle_done", done, 1'b0);
        check1("idle_err_hold", err, exp_err);
        checkv("idle_inv_hold", inv, exp_inv);
      end
    end
    // model transition at the coming rising edge
    if (!rst_n) begin
      mvalid  = 1;
      mbusy   = 0;
      exp_err = 1'b0;
      exp_inv = '0;
    end else if (mbusy) begin
      if (done) mbusy = 0;
    end else if (start) begin
      mbusy  = 1;
      macc_a = a;
      lat    = 0;
      accepts++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < LAT_MAX + 10) begin
      tick();
      n++;
    end
    check1("reached_idle", busy, 1'b0);
  endtask

  task automatic do_op(input logic [M-1:0] val);
    int n;
    wait_idle();
    start = 1'b1;
    a     = val;
    tick();
    start = 1'b0;
    a     = rand_a();
    n = 0;
    while (!done && n < LAT_MAX + 10) begin
      tick();
      n++;
    end
    check1("done_seen", done, 1'b1);
    tick();
  endtask

  initial begin
    one_v   = '0; one_v[0] = 1'b1;
    x_v     = '0; x_v[1]   = 1'b1;
    inv_x_v = '0; inv_x_v[408] = 1'b1; inv_x_v[86] = 1'b1;
    ones_v  = '1;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;

    // pin the reference multiply to hand-derived values
    begin
      logic [M-1:0] x408, x87p1;
      x408  = '0; x408[408] = 1'b1;
      x87p1 = '0; x87p1[87] = 1'b1; x87p1[0] = 1'b1;
      checkv("model_x_times_x408", gf_mul(x_v, x408), x87p1);
      checkv("model_x_times_invx", gf_mul(x_v, inv_x_v), one_v);
      checkv("model_times_one", gf_mul(ones_v, one_v), ones_v);
    end

    repeat (3) tick();
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_err", err, 1'b0);
    checkv("reset_inv", inv, '0);
    rst_n = 1'b1;
    tick();

    // T1, T2, T3
    do_op(one_v);
    do_op(x_v);
    do_op('0);
    do_op(one_v);

    // T4 random nonzero operands
    for (int i = 0; i < N_RAND; i++) do_op(rand_a());

    // T5 reset in the middle of a run
    wait_idle();
    start = 1'b1;
    a     = ones_v;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check1("still_running", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    checkv("abort_inv", inv, '0);
    tick();
    do_op(ones_v);

    // T6 start held high with a changing every cycle
    begin
      int acc0, res0;
      wait_idle();
      repeat (2) tick();
      acc0 = accepts;
      res0 = results;
      start = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        a = rand_a();
        tick();
      end
      start = 1'b0;
      wait_idle();
      repeat (3) tick();
      checki("held_start_ran_several", ((results - res0) >= 2) ? 1 : 0, 1);
      checki("held_start_one_result_per_accept", results - res0, accepts - acc0);
    end

    checki("total_results_match_accepts", results, accepts - 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
